// File: rtl/sal_axi_traffic_gen.sv
// sal_axi_traffic_gen: AXI4 write/read-back traffic generator.
// Each transaction writes one 32-byte INCR burst (two 128-bit beats), then
// reads the same address back and checks every beat, counting errors.
// Optional build macro SAL_TGEN_LFSR_EN: write data comes from a 32-bit Galois
// LFSR instead of the address pattern (lane w of beat k = A + 16k + 4w).
module sal_axi_traffic_gen #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [15:0]                 num_txn,
  input  logic [AXI_ADDR_WIDTH-1:0]   base_addr,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 err_cnt,
  output logic [AXI_ID_WIDTH-1:0]     awid,
  output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [AXI_DATA_WIDTH-1:0]   wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [AXI_ID_WIDTH-1:0]     bid,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready,
  output logic [AXI_ID_WIDTH-1:0]     arid,
  output logic [AXI_ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [AXI_ID_WIDTH-1:0]     rid,
  input  logic [AXI_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready
);

  localparam int LANES = AXI_DATA_WIDTH / 32;
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LO  = AXI_ADDR_WIDTH'(5'h1F);
  localparam logic [AXI_ADDR_WIDTH-1:0] TXN_SIZE = AXI_ADDR_WIDTH'(6'd32);

  typedef enum logic [2:0] {IDLE, WRITE, BRESP, RADDR, RDATA, NEXT} state_t;

  state_t                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]               cnt_q, cnt_d, err_q;
  logic                      busy_q, done_q;
  logic                      awvalid_q, wvalid_q, wbeat_q, bready_q;
  logic                      arvalid_q, rready_q, rbeat_q;
  logic [AXI_DATA_WIDTH-1:0] rexp;
  logic                      aw_fin, w_fin, b_err, r_err;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

`ifdef SAL_TGEN_LFSR_EN
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] LFSR_SEED = 32'hACE10001;

  // lfsr_q tracks write progress; lfsr_txn_q is the state at transaction
  // start so the read check can replay the same sequence.
  logic [31:0] lfsr_q, lfsr_txn_q, rchk_q;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int w = 0; w < LANES; w++) t = lfsr_step(t);
    return t;
  endfunction

  function automatic logic [AXI_DATA_WIDTH-1:0] lfsr_beat(input logic [31:0] s);
    logic [AXI_DATA_WIDTH-1:0] d;
    logic [31:0]               t;
    d = '0;
    t = s;
    for (int w = 0; w < LANES; w++) begin
      d[32*w +: 32] = t;
      t = lfsr_step(t);
    end
    return d;
  endfunction

  assign wdata = lfsr_beat(lfsr_q);
  assign rexp  = lfsr_beat(rchk_q);
`else
  function automatic logic [AXI_DATA_WIDTH-1:0] addr_beat(
      input logic [AXI_ADDR_WIDTH-1:0] a, input logic beat);
    logic [AXI_DATA_WIDTH-1:0] d;
    logic [AXI_ADDR_WIDTH-1:0] la;
    d = '0;
    for (int w = 0; w < LANES; w++) begin
      la = a + AXI_ADDR_WIDTH'({beat, 4'b0000}) + AXI_ADDR_WIDTH'(4 * w);
      d[32*w +: 32] = 32'(la);
    end
    return d;
  endfunction

  assign wdata = addr_beat(addr_q, wbeat_q);
  assign rexp  = addr_beat(addr_q, rbeat_q);
`endif

  // AW is finished once awvalid has dropped or is handshaking now; same for
  // W on its last beat. The two channels retire independently.
  assign aw_fin = !awvalid_q || awready;
  assign w_fin  = !wvalid_q || (wready && wbeat_q);
  assign b_err  = (bresp != 2'b00) || (bid != '0);
  assign r_err  = (rdata != rexp) || (rresp != 2'b00) || (rid != '0) || (rlast != rbeat_q);
  assign cnt_d  = cnt_q - 16'd1;
  assign addr_d = addr_q + TXN_SIZE;

  // Main sequencer: all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wbeat_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rbeat_q   <= 1'b0;
`ifdef SAL_TGEN_LFSR_EN
      lfsr_q     <= '0;
      lfsr_txn_q <= '0;
      rchk_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          err_q <= '0;
          if (num_txn == 16'd0) begin
            done_q <= 1'b1;
          end else begin
            busy_q    <= 1'b1;
            cnt_q     <= num_txn;
            addr_q    <= base_addr & ~ADDR_LO;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            wbeat_q   <= 1'b0;
            state_q   <= WRITE;
`ifdef SAL_TGEN_LFSR_EN
            lfsr_q     <= LFSR_SEED;
            lfsr_txn_q <= LFSR_SEED;
`endif
          end
        end
        WRITE: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready) begin
            wbeat_q <= 1'b1;
            if (wbeat_q) wvalid_q <= 1'b0;
`ifdef SAL_TGEN_LFSR_EN
            lfsr_q <= lfsr_adv(lfsr_q);
`endif
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= BRESP;
          end
        end
        BRESP: if (bvalid) begin
          if (b_err) err_q <= sat_inc(err_q);
          bready_q  <= 1'b0;
          arvalid_q <= 1'b1;
          state_q   <= RADDR;
        end
        RADDR: if (arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          rbeat_q   <= 1'b0;
          state_q   <= RDATA;
`ifdef SAL_TGEN_LFSR_EN
          rchk_q <= lfsr_txn_q;
`endif
        end
        RDATA: if (rvalid) begin
          if (r_err) err_q <= sat_inc(err_q);
          rbeat_q <= ~rbeat_q;
`ifdef SAL_TGEN_LFSR_EN
          rchk_q <= lfsr_adv(rchk_q);
`endif
          if (rlast) begin
            rready_q <= 1'b0;
            state_q  <= NEXT;
          end
        end
        NEXT: begin
          cnt_q  <= cnt_d;
          addr_q <= addr_d;
          if (cnt_d == 16'd0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            wbeat_q   <= 1'b0;
            state_q   <= WRITE;
`ifdef SAL_TGEN_LFSR_EN
            lfsr_txn_q <= lfsr_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cnt = err_q;
  assign awid    = '0;
  assign awaddr  = addr_q;
  assign awlen   = 8'd1;
  assign awsize  = 3'b100;
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;
  assign wstrb   = '1;
  assign wlast   = wbeat_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign arid    = '0;
  assign araddr  = addr_q;
  assign arlen   = 8'd1;
  assign arsize  = 3'b100;
  assign arburst = 2'b01;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

endmodule

// File: tb/tb_sal_axi_traffic_gen.sv
// Testbench for sal_axi_traffic_gen: echoing-memory AXI slave with optional
// random stalls and error injection, reference model filling a scoreboard at
// each start, and a monitor that checks every DUT handshake and done pulse.
module tb_sal_axi_traffic_gen;
  logic         clk = 1'b0, rst_n, start;
  logic [15:0]  num_txn, err_cnt;
  logic [31:0]  base_addr, awaddr, araddr;
  logic         busy, done;
  logic [3:0]   awid, arid, bid, rid;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [1:0]   awburst, arburst, bresp, rresp;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;

  always #5 clk = ~clk;

  sal_axi_traffic_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_txn(num_txn), .base_addr(base_addr),
    .busy(busy), .done(done), .err_cnt(err_cnt),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s", msg);
  endtask

  // scoreboard
  typedef struct packed { logic last; logic [127:0] data; } wbeat_t;
  logic [31:0] exp_aw[$], exp_ar[$];
  wbeat_t      exp_w[$];
  logic [15:0] exp_done[$];

  // slave configuration and shared state
  bit   cfg_rnd = 1'b0;
  int   cfg_aw_delay = 0, cfg_berr_at = -1, cfg_rc_at = -1, cfg_rc_beat = 0;
  int   bcnt = 0, rtxn = 0;
  logic [127:0] mem [logic [31:0]];

  // AXI slave: decides inputs just after each edge for the following edge
  initial begin : slave
    logic [31:0]  waq[$], raq[$], a;
    logic [127:0] wbq[$], d;
    int aw_wait, rbeat;
    bit b_hs, r_hs;
    aw_wait = 0; rbeat = 0; b_hs = 0; r_hs = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0; arready = 0;
    rvalid = 0; rid = 0; rdata = '0; rresp = 0; rlast = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        waq.delete(); raq.delete(); wbq.delete();
        aw_wait = 0; rbeat = 0; b_hs = 0; r_hs = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
      end else begin
        if (b_hs) begin bvalid = 0; b_hs = 0; bcnt++; end
        if (!bvalid && waq.size() > 0 && wbq.size() >= 2 && (!cfg_rnd || $urandom_range(0, 1) == 0)) begin
          a = waq.pop_front();
          mem[a] = wbq.pop_front();
          mem[a + 32'd16] = wbq.pop_front();
          bvalid = 1; bid = 0;
          bresp = (bcnt == cfg_berr_at) ? 2'b10 : 2'b00;
        end
        b_hs = bvalid && bready;
        if (r_hs) begin
          rvalid = 0; r_hs = 0;
          if (rbeat == 1) begin rbeat = 0; a = raq.pop_front(); rtxn++; end
          else rbeat = 1;
        end
        if (!rvalid && raq.size() > 0 && (!cfg_rnd || $urandom_range(0, 1) == 0)) begin
          a = raq[0] + 32'(16 * rbeat);
          d = mem.exists(a) ? mem[a] : '0;
          if (rtxn == cfg_rc_at && rbeat == cfg_rc_beat) d[0] = ~d[0];
          rdata = d; rvalid = 1; rlast = (rbeat == 1); rid = 0; rresp = 0;
        end
        r_hs = rvalid && rready;
        if (awvalid) begin
          awready = cfg_rnd ? ($urandom_range(0, 2) != 0) : (aw_wait >= cfg_aw_delay);
          aw_wait++;
        end else begin
          awready = cfg_rnd ? ($urandom_range(0, 1) == 1) : (cfg_aw_delay == 0);
          aw_wait = 0;
        end
        if (awvalid && awready) waq.push_back(awaddr);
        wready = cfg_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (wvalid && wready) wbq.push_back(wdata);
        arready = cfg_rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (arvalid && arready) raq.push_back(araddr);
      end
    end
  end

  // monitor: compares every DUT handshake and done pulse with the scoreboard
  initial begin : monitor
    bit          aw_stall;
    logic [48:0] aw_hold;
    aw_stall = 0;
    aw_hold  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin aw_stall = 0; continue; end
      if (aw_stall && awvalid)
        chk("aw_stable", 256'({awid, awaddr, awlen, awsize, awburst}), 256'(aw_hold));
      if (awvalid || wvalid || arvalid || bready || rready)
        chk("busy_active", 256'(busy), 256'(1));
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) fail($sformatf("aw_unexpected: got AW addr %0h, expected none", awaddr));
        else chk("aw", 256'({awid, awaddr, awlen, awsize, awburst}),
                 256'({4'h0, exp_aw.pop_front(), 8'd1, 3'b100, 2'b01}));
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) fail($sformatf("w_unexpected: got W data %0h, expected none", wdata));
        else begin
          wbeat_t e;
          e = exp_w.pop_front();
          chk("w", 256'({wlast, wdata, wstrb}), 256'({e.last, e.data, 16'hFFFF}));
        end
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) fail($sformatf("ar_unexpected: got AR addr %0h, expected none", araddr));
        else chk("ar", 256'({arid, araddr, arlen, arsize, arburst}),
                 256'({4'h0, exp_ar.pop_front(), 8'd1, 3'b100, 2'b01}));
      end
      if (done) begin
        if (exp_done.size() == 0) fail("done_unexpected: got done pulse, expected none");
        else chk("done_err_cnt", 256'(err_cnt), 256'(exp_done.pop_front()));
      end
      aw_stall = awvalid && !awready;
      aw_hold  = {awid, awaddr, awlen, awsize, awburst};
    end
  end

  // reference model + start: each txn writes then reads A = base&~31 + 32t,
  // lane w of beat k holds A + 16k + 4w; err_cnt counts injected faults.
  task automatic run(input logic [31:0] base, input int n, input int berr_k,
                     input int rc_k, input int rc_beat, input bit wait_done);
    logic [31:0]  a;
    logic [127:0] d;
    wbeat_t       e;
    int           nerr, cyc;
    nerr = 0;
    cfg_berr_at = (berr_k < 0) ? -1 : bcnt + berr_k;
    cfg_rc_at   = (rc_k < 0) ? -1 : rtxn + rc_k;
    cfg_rc_beat = rc_beat;
    for (int t = 0; t < n; t++) begin
      a = (base & 32'hFFFF_FFE0) + 32'(32 * t);
      exp_aw.push_back(a);
      exp_ar.push_back(a);
      for (int k = 0; k < 2; k++) begin
        for (int w = 0; w < 4; w++) d[32*w +: 32] = a + 32'(16 * k + 4 * w);
        e.last = (k == 1);
        e.data = d;
        exp_w.push_back(e);
      end
    end
    if (berr_k >= 0 && berr_k < n) nerr++;
    if (rc_k >= 0 && rc_k < n) nerr++;
    exp_done.push_back(16'(nerr));
    @(posedge clk); #1;
    start = 1; num_txn = 16'(n); base_addr = base;
    @(posedge clk); #1;
    start = 0;
    if (n == 0) begin
      chk("zero_done", 256'(done), 256'(1));
      chk("zero_busy", 256'(busy), 256'(0));
      chk("zero_no_valid", 256'({awvalid, wvalid, arvalid}), 256'(0));
    end else begin
      chk("start_busy", 256'(busy), 256'(1));
    end
    if (!wait_done) return;
    cyc = 0;
    while (!done && cyc < 200 + 100 * n) begin @(posedge clk); #1; cyc++; end
    if (!done) fail($sformatf("timeout: got no done within %0d cycles, expected done", cyc));
    else chk("end_busy", 256'(busy), 256'(0));
    @(negedge clk); #1;
    chk("sb_drained", 256'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_done.size()), 256'(0));
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, x, bk, rk, cyc;
    logic [31:0] b;
    rst_n = 0; start = 0; num_txn = 0; base_addr = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy_done", 256'({busy, done}), 256'(0));
    chk("rst_err_cnt", 256'(err_cnt), 256'(0));
    chk("rst_valid_ready", 256'({awvalid, wvalid, bready, arvalid, rready}), 256'(0));
    chk("rst_addr", 256'(awaddr), 256'(0));
    rst_n = 1;

    // basic two transactions, always ready
    run(32'h0, 2, -1, -1, 0, 1);
    chk("mem_beat0", 256'(mem[32'h0]), 256'(128'h0000000C_00000008_00000004_00000000));
    // zero transactions
    run(32'h0, 0, -1, -1, 0, 1);
    // corrupt bit 0 of the second read beat at 0x20
    run(32'h0, 2, -1, 1, 1, 1);
    // awready held off 5 cycles
    cfg_aw_delay = 5;
    run(32'h0000_1000, 1, -1, -1, 0, 1);
    cfg_aw_delay = 0;
    // SLVERR on txn 0
    run(32'h0000_2000, 2, 0, -1, 0, 1);
    // address wrap; unaligned low bits ignored
    run(32'hFFFF_FFE0, 2, -1, -1, 0, 1);
    run(32'h0000_305B, 1, -1, -1, 0, 1);

    // random slave timing and fault injection
    cfg_rnd = 1;
    for (int i = 0; i < 8; i++) begin
      n  = int'($urandom_range(1, 5));
      b  = $urandom;
      x  = int'($urandom_range(0, n)); bk = (x == n) ? -1 : x;
      x  = int'($urandom_range(0, n)); rk = (x == n) ? -1 : x;
      run(b, n, bk, rk, int'($urandom_range(0, 1)), 1);
    end
    cfg_rnd = 0;

    // reset during RDATA aborts immediately
    run(32'h0000_0100, 3, -1, -1, 0, 0);
    cyc = 0;
    while (!rready && cyc < 200) begin @(posedge clk); #1; cyc++; end
    if (!rready) fail("reach_rdata: got no rready, expected rready");
    #2 rst_n = 0;
    #1;
    chk("abort_valid_ready", 256'({awvalid, wvalid, arvalid, bready, rready}), 256'(0));
    chk("abort_busy_done", 256'({busy, done}), 256'(0));
    chk("abort_err_addr", 256'({err_cnt, awaddr}), 256'(0));
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_done.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run(32'h0000_0040, 1, -1, -1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sal_axi_traffic_gen.md
SAL_AXI_TRAFFIC_GEN -- requirements
Module: sal_axi_traffic_gen

Interface
REQ-001 Parameter AXI_ID_WIDTH, default 4, width of all AXI ID fields.
REQ-002 Parameter AXI_ADDR_WIDTH, default 32, width of awaddr/araddr/base_addr.
REQ-003 Parameter AXI_DATA_WIDTH, default 128, fixed at 128; strobe width 16.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset, named clk and rst_n.
REQ-005 clk  input  1  clock for all logic.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse; begins a run, ignored while busy=1.
REQ-008 num_txn  input  16  transaction count, sampled at start; 0 means no transactions.
REQ-009 base_addr  input  AXI_ADDR_WIDTH  first address, sampled at start; bits [4:0] forced to 0.
REQ-010 busy / done  output  1 / 1  run in progress / one-cycle pulse at run end.
REQ-011 err_cnt  output  16  mismatched 128-bit read beats plus non-OKAY responses, saturating.
REQ-012 aw{id,addr,len,size,burst,valid} output, awready input  AW channel.
REQ-013 w{data,strb,last,valid} output, wready input  W channel.
REQ-014 b{id,resp,valid} input, bready output  B channel.
REQ-015 ar{id,addr,len,size,burst,valid} output, arready input  AR channel.
REQ-016 r{id,data,resp,last,valid} input, rready output  R channel.

Function
REQ-017 Each transaction SHALL be a 32-byte write followed by a 32-byte read-back of the same address: id=0, len=1, size=3'b100, burst=INCR, wstrb=16'hFFFF.
REQ-018 FSM states SHALL be IDLE, WRITE, BRESP, RADDR, RDATA, NEXT; IDLE->WRITE on start with num_txn!=0; IDLE->done pulse on start with num_txn==0.
REQ-019 In WRITE, awvalid and wvalid SHALL assert in the same cycle after entry; AW and W complete independently; WRITE->BRESP once AW handshake and both W beats (wlast on beat 1) are done.
REQ-020 Valid signals and payloads SHALL remain stable until the matching ready handshake.
REQ-021 bready SHALL be 1 only in BRESP; BRESP->RADDR on bvalid; bresp!=OKAY or bid!=0 increments err_cnt.
REQ-022 RADDR->RDATA on arvalid&&arready; rready SHALL be 1 only in RDATA.
REQ-023 Each R beat SHALL be compared with the expected data; mismatch, rresp!=OKAY, rid!=0, or rlast wrong for the beat index each add 1 to err_cnt (max 1 per beat).
REQ-024 RDATA->NEXT after the rlast=1 beat; NEXT decrements remaining count, adds 32 to address (wraps modulo 2^AXI_ADDR_WIDTH), returns to WRITE or raises done and goes IDLE.
REQ-025 Default data: 32-bit lane w of beat k at address A SHALL equal A+16k+4w.
REQ-026 busy SHALL be 1 from the cycle after accepted start until the cycle done pulses.
REQ-027 err_cnt SHALL clear on accepted start and saturate at 16'hFFFF.

Reset
REQ-028 On rst_n=0: FSM to IDLE; all valid/ready outputs, busy, done 0; err_cnt 0; address/count registers 0.
REQ-029 Reset asserted mid-transaction SHALL abort immediately without completing outstanding channel handshakes.

Configuration
REQ-030 Macro SAL_TGEN_LFSR_EN defined: write data from a 32-bit Galois LFSR (polynomial 32'h80200003, seed 32'hACE10001 reloaded on start), advanced once per 32-bit lane, lane 0 first; read check regenerates the sequence from the LFSR state saved at transaction start.
REQ-031 Macro undefined: address-based pattern of REQ-025; no LFSR logic is present.

Verification
REQ-032 base_addr=0, num_txn=2, slave always ready, echoing memory -> writes at 0x0 and 0x20, beat 0 of txn 0 = {32'hC,32'h8,32'h4,32'h0}, done pulses, err_cnt=0.
REQ-033 num_txn=0 start -> done next cycle, no AXI valid asserted, busy stays 0.
REQ-034 Memory corrupts bit 0 of second read beat at 0x20 -> err_cnt=1 at done.
REQ-035 awready delayed 5 cycles, wready always 1 -> both W beats complete first, AW payload held stable, transaction completes, err_cnt=0.
REQ-036 bresp=SLVERR on txn 0, else OKAY -> err_cnt=1; read-back still performed.
REQ-037 base_addr=32'hFFFFFFE0, num_txn=2 -> second transaction at address 0x0; rst_n pulsed low during RDATA -> all outputs reset values next cycle.
